// File: rtl/chimera_pmu_pkg.sv
// Shared types and sizing helpers for the chimera cluster power-management controller.
package chimera_pmu_pkg;

  typedef enum logic [2:0] {
    PmuOn      = 3'd0,
    PmuIsoWait = 3'd1,
    PmuClkOff  = 3'd2,
    PmuRstOn   = 3'd3,
    PmuOff     = 3'd4,
    PmuRstHold = 3'd5,
    PmuRstRel  = 3'd6,
    PmuIsoRel  = 3'd7
  } pmu_state_e;

  typedef enum logic {
    PmuOpDown = 1'b0,
    PmuOpUp   = 1'b1
  } pmu_op_e;

  // Wide enough to hold the longest wait plus one headroom bit for saturation.
  function automatic int pmu_cnt_width(input int rst_hold, input int clk_settle,
                                       input int ack_timeout);
    int longest;
    longest = rst_hold;
    if (clk_settle > longest) longest = clk_settle;
    if (ack_timeout > longest) longest = ack_timeout;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/chimera_pmu_cluster_fsm.sv
// Power sequencer for a single cluster: isolation, clock gate and reset ordering with
// a per-cluster wait counter and a sticky acknowledge-timeout flag.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ON         | cluster powered and running, isolation released
// ISO_WAIT   | isolation requested, waiting for iso_ack high
// CLK_OFF    | clock gated, settling before reset
// RST_ON     | reset asserted for one cycle
// OFF        | isolated, clock gated, held in reset
// RST_HOLD   | clock running, reset held low
// RST_REL    | reset released, settling before isolation release
// ISO_REL    | isolation released, waiting for iso_ack low
module chimera_pmu_cluster_fsm
  import chimera_pmu_pkg::*;
#(
  parameter int RstHoldCycles   = 8,
  parameter int ClkSettleCycles = 4,
  parameter int AckTimeout      = 256
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    start_i,
  input  pmu_op_e op_i,
  input  logic    err_clr_i,
  input  logic    iso_ack_i,
  output logic    idle_o,
  output logic    iso_en_o,
  output logic    clkgate_en_o,
  output logic    rst_no,
  output logic    status_on_o,
  output logic    busy_o,
  output logic    err_o
);

  localparam int CntW = pmu_cnt_width(RstHoldCycles, ClkSettleCycles, AckTimeout);
  localparam logic [CntW-1:0] HoldLast   = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] AckLast    = CntW'(AckTimeout - 1);

  pmu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            timeout;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      PmuOn:      if (start_i && op_i == PmuOpDown) state_d = PmuIsoWait;
      PmuIsoWait: begin
        if (iso_ack_i) begin
          state_d = PmuClkOff;
        end else if (cnt_q == AckLast) begin
          state_d = PmuOn;
          timeout = 1'b1;
        end
      end
      PmuClkOff:  if (cnt_q == SettleLast) state_d = PmuRstOn;
      PmuRstOn:   state_d = PmuOff;
      PmuOff:     if (start_i && op_i == PmuOpUp) state_d = PmuRstHold;
      PmuRstHold: if (cnt_q == HoldLast) state_d = PmuRstRel;
      PmuRstRel:  if (cnt_q == SettleLast) state_d = PmuIsoRel;
      PmuIsoRel: begin
        if (!iso_ack_i) begin
          state_d = PmuOn;
        end else if (cnt_q == AckLast) begin
          state_d = PmuOn;
          timeout = 1'b1;
        end
      end
      default:    state_d = PmuOn;
    endcase
  end

  assign idle_o = (state_q == PmuOn) || (state_q == PmuOff);

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PmuOn;
      cnt_q        <= '0;
      iso_en_o     <= 1'b0;
      clkgate_en_o <= 1'b1;
      rst_no       <= 1'b1;
      status_on_o  <= 1'b1;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      iso_en_o     <= !(state_d inside {PmuOn, PmuIsoRel});
      clkgate_en_o <= !(state_d inside {PmuClkOff, PmuRstOn, PmuOff});
      rst_no       <= !(state_d inside {PmuRstOn, PmuOff, PmuRstHold});
      status_on_o  <= (state_d == PmuOn);
      busy_o       <= !(state_d inside {PmuOn, PmuOff});
      if (timeout) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chimera_pmu_ctrl.sv
// Cluster power-management controller: decodes one command per cycle onto independent
// per-cluster sequencers driving the wrapper's PMU isolation/clock/reset interface.
module chimera_pmu_ctrl
  import chimera_pmu_pkg::*;
#(
  parameter int NumClusters     = 5,
  parameter int RstHoldCycles   = 8,
  parameter int ClkSettleCycles = 4,
  parameter int AckTimeout      = 256,
  localparam int IdxW           = $clog2(NumClusters)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [IdxW-1:0]        cmd_cluster_i,
  input  logic                   cmd_op_i,
  input  logic                   err_clr_i,
  output logic [NumClusters-1:0] status_on_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] err_o,
  output logic [NumClusters-1:0] pmu_iso_en_clusters_o,
  input  logic [NumClusters-1:0] pmu_iso_ack_clusters_i,
  output logic [NumClusters-1:0] pmu_clkgate_en_clusters_o,
  output logic [NumClusters-1:0] pmu_rst_clusters_no
);

  logic [NumClusters-1:0] idle;
  logic [NumClusters-1:0] start;
  pmu_op_e                op;

  assign op = pmu_op_e'(cmd_op_i);

  // Out-of-range indices match no cluster, so they keep the default ready and are dropped.
  always_comb begin
    cmd_ready_o = 1'b1;
    for (int i = 0; i < NumClusters; i++) begin
      if (cmd_cluster_i == IdxW'(i)) cmd_ready_o = idle[i];
    end
  end

  always_comb begin
    start = '0;
    for (int i = 0; i < NumClusters; i++) begin
      start[i] = cmd_valid_i && cmd_ready_o && (cmd_cluster_i == IdxW'(i));
    end
  end

  for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
    chimera_pmu_cluster_fsm #(
      .RstHoldCycles  (RstHoldCycles),
      .ClkSettleCycles(ClkSettleCycles),
      .AckTimeout     (AckTimeout)
    ) u_fsm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start[g]),
      .op_i        (op),
      .err_clr_i   (err_clr_i),
      .iso_ack_i   (pmu_iso_ack_clusters_i[g]),
      .idle_o      (idle[g]),
      .iso_en_o    (pmu_iso_en_clusters_o[g]),
      .clkgate_en_o(pmu_clkgate_en_clusters_o[g]),
      .rst_no      (pmu_rst_clusters_no[g]),
      .status_on_o (status_on_o[g]),
      .busy_o      (busy_o[g]),
      .err_o       (err_o[g])
    );
  end

endmodule

// File: tb/tb_chimera_pmu_ctrl.sv
// Self-checking bench for chimera_pmu_ctrl: timeline-based reference model plus directed
// and randomized command/acknowledge stimulus.
module tb_chimera_pmu_ctrl;

  localparam int N = 5;
  localparam int H = 8;
  localparam int S = 4;
  localparam int T = 256;

  logic         clk = 1'b0;
  logic         rst, cmd_valid, cmd_op, err_clr, cmd_ready;
  logic [2:0]   cmd_cluster;
  logic [N-1:0] ack, status_on, busy, err, iso_en, clkgate_en, rst_n;

  always #5 clk = ~clk;

  chimera_pmu_ctrl #(
    .NumClusters(N), .RstHoldCycles(H), .ClkSettleCycles(S), .AckTimeout(T)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .cmd_valid_i              (cmd_valid),
    .cmd_ready_o              (cmd_ready),
    .cmd_cluster_i            (cmd_cluster),
    .cmd_op_i                 (cmd_op),
    .err_clr_i                (err_clr),
    .status_on_o              (status_on),
    .busy_o                   (busy),
    .err_o                    (err),
    .pmu_iso_en_clusters_o    (iso_en),
    .pmu_iso_ack_clusters_i   (ack),
    .pmu_clkgate_en_clusters_o(clkgate_en),
    .pmu_rst_clusters_no      (rst_n)
  );

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     cmd_p = 1;

  // Reference model: last accepted sequence per cluster (direction, accept edge, ack delay).
  // Ack delay p: the wrapper presents the requested ack level from edge e+p on; p > T never.
  bit     rec_valid[N];
  bit     rec_up[N];
  longint rec_e[N];
  int     rec_p[N];
  bit     err_m[N];

  logic         rdy_obs, rdy_exp;
  logic [N-1:0] x_iso, x_clk, x_rstn, x_on, x_busy, x_err;

  // Expected {iso_en, clkgate_en, rst_n, status_on, busy} after edge n.
  function automatic logic [4:0] exp_vec(int i, longint n);
    longint k;
    int     p;
    if (!rec_valid[i]) return 5'b01110;
    k = n - rec_e[i];
    p = rec_p[i];
    if (!rec_up[i]) begin
      if (p > T) return (k < T) ? 5'b11101 : 5'b01110;
      if (k < p) return 5'b11101;
      if (k < p + S) return 5'b10101;
      if (k == p + S) return 5'b10001;
      return 5'b10000;
    end
    if (k < H) return 5'b11001;
    if (k < H + S) return 5'b11101;
    if (k < H + S + ((p > T) ? T : p)) return 5'b01101;
    return 5'b01110;
  endfunction

  function automatic logic ack_fn(int i, longint m);
    if (!rec_valid[i]) return 1'b0;
    if (!rec_up[i]) return (rec_p[i] <= T) && (m >= rec_e[i] + rec_p[i]);
    if (rec_p[i] > T) return 1'b1;
    return m < rec_e[i] + H + S + rec_p[i];
  endfunction

  function automatic logic timeout_at(int i, longint m);
    if (!rec_valid[i] || rec_p[i] <= T) return 1'b0;
    return m == rec_e[i] + (rec_up[i] ? H + S + T : T);
  endfunction

  function automatic logic ready_fn(logic [2:0] idx, longint n);
    logic [4:0] v;
    if (int'(idx) >= N) return 1'b1;
    v = exp_vec(int'(idx), n);
    return !v[0];
  endfunction

  // Advance one clock: drive ack, sample ready, update the model at the edge.
  task automatic step();
    longint     m;
    logic       acc;
    logic [4:0] v;
    m = cyc + 1;
    for (int i = 0; i < N; i++) ack[i] = ack_fn(i, m);
    @(negedge clk);
    rdy_obs = cmd_ready;
    rdy_exp = ready_fn(cmd_cluster, cyc);
    acc = cmd_valid && rdy_exp;
    @(posedge clk);
    cyc = m;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        rec_valid[i] = 1'b0;
        err_m[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (timeout_at(i, m)) err_m[i] = 1'b1;
        else if (err_clr) err_m[i] = 1'b0;
      end
      if (acc && int'(cmd_cluster) < N) begin
        v = exp_vec(int'(cmd_cluster), m - 1);
        if ((v[1] && !cmd_op) || (!v[1] && !v[0] && cmd_op)) begin
          rec_valid[cmd_cluster] = 1'b1;
          rec_up[cmd_cluster] = cmd_op;
          rec_e[cmd_cluster] = m;
          rec_p[cmd_cluster] = cmd_p;
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      v = exp_vec(i, cyc);
      {x_iso[i], x_clk[i], x_rstn[i], x_on[i], x_busy[i]} = v;
      x_err[i] = err_m[i];
    end
  endtask

  task automatic issue(input logic [2:0] idx, input logic op, input int p);
    cmd_valid = 1'b1;
    cmd_cluster = idx;
    cmd_op = op;
    cmd_p = p;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_cluster = 3'd0; cmd_op = 1'b0; err_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {5'h00, 5'h1f, 5'h1f, 5'h1f, 5'h00, 5'h00}) begin
      failures++;
      $display("FAIL reset_values got=%b %b %b %b %b %b", iso_en, clkgate_en, rst_n, status_on, busy, err);
    end
    checks++;
    if (rdy_obs !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", rdy_obs);
    end
  endtask

  task automatic test_power_down();
    longint t_iso = -1, t_clk = -1, t_rst = -1;
    issue(3'd2, 1'b0, 3);
    checks++;
    if (rdy_obs !== 1'b1) begin
      failures++;
      $display("FAIL pd_ready got=%b exp=1", rdy_obs);
    end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
        failures++;
        $display("FAIL pd_outputs cyc=%0d got=%b %b %b %b %b %b exp=%b %b %b %b %b %b", cyc,
                 iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
      end
      if (t_iso < 0 && iso_en[2]) t_iso = cyc;
      if (t_clk < 0 && !clkgate_en[2]) t_clk = cyc;
      if (t_rst < 0 && !rst_n[2]) t_rst = cyc;
      step();
    end
    checks++;
    if (t_iso < 0 || t_clk - t_iso != 3 || t_rst - t_clk != S) begin
      failures++;
      $display("FAIL pd_timing iso=%0d clk_off=%0d rst_on=%0d exp gaps 3 and %0d", t_iso, t_clk, t_rst, S);
    end
    checks++;
    if (status_on !== 5'b11011 || iso_en !== 5'b00100 || clkgate_en !== 5'b11011) begin
      failures++;
      $display("FAIL pd_final status_on=%b iso=%b clk=%b exp 11011 00100 11011", status_on, iso_en, clkgate_en);
    end
  endtask

  task automatic test_power_up();
    int     hold = 0;
    longint t_rel = -1, t_isodrop = -1, t_on = -1;
    issue(3'd2, 1'b1, 2);
    for (int n = 0; n < 24; n++) begin
      checks++;
      if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
        failures++;
        $display("FAIL pu_outputs cyc=%0d got=%b %b %b %b %b %b exp=%b %b %b %b %b %b", cyc,
                 iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
      end
      if (clkgate_en[2] && !rst_n[2]) hold++;
      if (t_rel < 0 && rst_n[2]) t_rel = cyc;
      if (t_isodrop < 0 && !iso_en[2]) t_isodrop = cyc;
      if (t_on < 0 && status_on[2]) t_on = cyc;
      step();
    end
    checks++;
    if (hold != H) begin
      failures++;
      $display("FAIL pu_rst_hold got=%0d exp=%0d", hold, H);
    end
    checks++;
    if (t_rel < 0 || t_isodrop - t_rel != S || t_on - t_isodrop != 2) begin
      failures++;
      $display("FAIL pu_timing rel=%0d iso_drop=%0d on=%0d exp gaps %0d and 2", t_rel, t_isodrop, t_on, S);
    end
  endtask

  task automatic test_timeout();
    issue(3'd0, 1'b0, 1000);
    for (int n = 0; n < T + 4; n++) begin
      checks++;
      if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
        failures++;
        $display("FAIL to_outputs cyc=%0d got=%b %b %b %b %b %b exp=%b %b %b %b %b %b", cyc,
                 iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
      end
      step();
    end
    checks++;
    if (err[0] !== 1'b1 || iso_en[0] !== 1'b0 || status_on[0] !== 1'b1) begin
      failures++;
      $display("FAIL to_final err=%b iso=%b on=%b exp 1 0 1", err[0], iso_en[0], status_on[0]);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err[0] !== 1'b0) begin
      failures++;
      $display("FAIL to_err_clr got=%b exp=0", err[0]);
    end
    // Second timeout with err_clr asserted on the very edge the timeout fires.
    issue(3'd0, 1'b0, 1000);
    for (int n = 0; n < T && cyc < rec_e[0] + T - 1; n++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err[0] !== 1'b1) begin
      failures++;
      $display("FAIL to_set_wins got=%b exp=1", err[0]);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    // Ack arriving on the last allowed cycle still completes without error.
    issue(3'd0, 1'b0, T);
    for (int n = 0; n < T + S + 4; n++) step();
    checks++;
    if (err[0] !== 1'b0 || status_on[0] !== 1'b0 || rst_n[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL to_last_cycle_ack err=%b on=%b rst_n=%b busy=%b exp 0 0 0 0", err[0], status_on[0], rst_n[0], busy[0]);
    end
    issue(3'd0, 1'b1, 1);
    for (int n = 0; n < H + S + 4; n++) step();
    checks++;
    if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
      failures++;
      $display("FAIL to_repower got=%b %b %b %b %b %b exp=%b %b %b %b %b %b",
               iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
    end
  endtask

  task automatic test_busy_concurrent();
    bit found = 1'b0;
    int waits = 0;
    issue(3'd1, 1'b0, 2);
    issue(3'd3, 1'b0, 2);
    checks++;
    if (rdy_obs !== 1'b1 || busy[3] !== 1'b1 || busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL bc_concurrent ready=%b busy=%b exp ready=1 busy[3]=busy[1]=1", rdy_obs, busy);
    end
    cmd_valid = 1'b1; cmd_cluster = 3'd1; cmd_op = 1'b1; cmd_p = 1;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      checks++;
      if (rdy_obs !== rdy_exp) begin
        failures++;
        $display("FAIL bc_ready cyc=%0d got=%b exp=%b", cyc, rdy_obs, rdy_exp);
      end
      if (rdy_obs === 1'b1) found = 1'b1;
      else waits++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!found || waits == 0) begin
      failures++;
      $display("FAIL bc_wait found=%0d waits=%0d exp found with waits>0", found, waits);
    end
    issue(3'd3, 1'b1, 1);
    for (int n = 0; n < H + S + 4; n++) begin
      checks++;
      if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
        failures++;
        $display("FAIL bc_outputs cyc=%0d got=%b %b %b %b %b %b exp=%b %b %b %b %b %b", cyc,
                 iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
      end
      step();
    end
    checks++;
    if (status_on !== 5'b11111 || busy !== 5'b00000) begin
      failures++;
      $display("FAIL bc_final status_on=%b busy=%b exp 11111 00000", status_on, busy);
    end
  endtask

  task automatic test_out_of_range();
    logic [6*N-1:0] snap;
    logic [2:0]     idx_tbl[3] = '{3'd7, 3'd5, 3'd4};
    logic           op_tbl[3]  = '{1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) begin
      snap = {iso_en, clkgate_en, rst_n, status_on, busy, err};
      issue(idx_tbl[j], op_tbl[j], 1);
      step();
      checks++;
      if (rdy_obs !== 1'b1 || {iso_en, clkgate_en, rst_n, status_on, busy, err} !== snap) begin
        failures++;
        $display("FAIL oor_noop idx=%0d ready=%b got=%b exp=%b", idx_tbl[j], rdy_obs,
                 {iso_en, clkgate_en, rst_n, status_on, busy, err}, snap);
      end
    end
  endtask

  task automatic test_reset_mid_seq();
    issue(3'd4, 1'b0, 1);
    for (int n = 0; n < S + 4; n++) step();
    issue(3'd4, 1'b1, 1);
    step();
    step();
    checks++;
    if (busy[4] !== 1'b1 || rst_n[4] !== 1'b0 || clkgate_en[4] !== 1'b1) begin
      failures++;
      $display("FAIL rm_in_hold busy=%b rst_n=%b clk=%b exp 1 0 1", busy[4], rst_n[4], clkgate_en[4]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {5'h00, 5'h1f, 5'h1f, 5'h1f, 5'h00, 5'h00}) begin
      failures++;
      $display("FAIL rm_reset_values got=%b %b %b %b %b %b", iso_en, clkgate_en, rst_n, status_on, busy, err);
    end
    step();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = 1'($urandom_range(1));
      cmd_cluster = 3'($urandom_range(7));
      cmd_op = 1'($urandom_range(1));
      r = $urandom_range(99);
      cmd_p = (r < 3) ? 1000 : (r < 5) ? T : $urandom_range(5, 1);
      err_clr = ($urandom_range(99) < 3);
      rst = ($urandom_range(999) == 0);
      step();
      checks++;
      if (rdy_obs !== rdy_exp) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d idx=%0d got=%b exp=%b", cyc, cmd_cluster, rdy_obs, rdy_exp);
      end
      checks++;
      if ({iso_en, clkgate_en, rst_n, status_on, busy, err} !== {x_iso, x_clk, x_rstn, x_on, x_busy, x_err}) begin
        failures++;
        $display("FAIL rnd_outputs cyc=%0d got=%b %b %b %b %b %b exp=%b %b %b %b %b %b", cyc,
                 iso_en, clkgate_en, rst_n, status_on, busy, err, x_iso, x_clk, x_rstn, x_on, x_busy, x_err);
      end
    end
    cmd_valid = 1'b0;
    err_clr = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    ack = '0;
    for (int i = 0; i < N; i++) begin
      rec_valid[i] = 1'b0;
      rec_up[i] = 1'b0;
      rec_e[i] = 0;
      rec_p[i] = 1;
      err_m[i] = 1'b0;
    end
    test_reset();
    test_power_down();
    test_power_up();
    test_timeout();
    test_busy_concurrent();
    test_out_of_range();
    test_reset_mid_seq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
